tt_ctrl_sel: RTL and testbench

- Design-select sequencer inside the controller.
- Converts the raw control pads (select reset, select increment, enable) into a clean design address and a gated enable.
- These drive the address and enable fields of the vertical spine, which every branch mux decodes.
- Synchronises and glitch-filters the pads, counts increment pulses, and holds enable low while the spine address settles.

---
 rtl/tt_ctrl_sel_if.sv | 22 ++
 rtl/tt_ctrl_sel.sv | 134 +++++++++++++
 tb/tb_tt_ctrl_sel.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/tt_ctrl_sel_if.sv
// Spine-side bundle for the design-select sequencer: raw control pads in,
// clean address / gated enable / busy out.
interface tt_ctrl_sel_if #(
    parameter int AW = 10
);
    logic          pad_sel_rst_n;
    logic          pad_sel_inc;
    logic          pad_ena;
    logic [AW-1:0] sel_addr;
    logic          sel_ena;
    logic          sel_busy;

    modport master (
        output pad_sel_rst_n, pad_sel_inc, pad_ena,
        input  sel_addr, sel_ena, sel_busy
    );

    modport slave (
        input  pad_sel_rst_n, pad_sel_inc, pad_ena,
        output sel_addr, sel_ena, sel_busy
    );
endinterface

// File: rtl/tt_ctrl_sel.sv
// Design-select sequencer: synchronise and glitch-filter the control pads,
// count increment pulses into the spine address and gate enable while it settles.
module tt_ctrl_sel_pad #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad,
    output logic filt
);
    localparam int CW = $clog2(FILT_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Level only moves after FILT_LEN consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            filt   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
            if (sync_out == filt) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILT_LEN - 1)) begin
                filt  <= sync_out;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end
endmodule

module tt_ctrl_sel #(
    parameter int AW          = 10,
    parameter int MAX_ADDR    = 1023,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int SETTLE_CYC  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    tt_ctrl_sel_if.slave   bus
);
    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {HOLD, SETTLE, ACTIVE} state_t;

    // Pad order: [0] select reset, [1] increment, [2] enable.
    logic [2:0] pad_raw;
    logic [2:0] pad_filt;

    assign pad_raw = {bus.pad_ena, bus.pad_sel_inc, bus.pad_sel_rst_n};

    tt_ctrl_sel_pad #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_pad [2:0] (
        .clk   (clk),
        .rst_n (rst_n),
        .pad   (pad_raw),
        .filt  (pad_filt)
    );

    logic sel_rst_f, inc_f, ena_f, inc_d, inc_p;
    assign sel_rst_f = pad_filt[0];
    assign inc_f     = pad_filt[1];
    assign ena_f     = pad_filt[2];
    assign inc_p     = inc_f & ~inc_d;

    state_t         state_q, state_nx;
    logic [AW-1:0]  addr_q, addr_nx;
    logic [SCW-1:0] cnt_q, cnt_nx;
    logic           ena_q, busy_q;

    always_comb begin
        state_nx = state_q;
        addr_nx  = addr_q;
        cnt_nx   = cnt_q;
        if (!sel_rst_f) begin
            state_nx = HOLD;
            addr_nx  = '0;
            cnt_nx   = '0;
        end else begin
            case (state_q)
                HOLD: begin
                    // An increment coinciding with release is deliberately dropped.
                    state_nx = SETTLE;
                    cnt_nx   = SCW'(SETTLE_CYC - 1);
                end
                SETTLE, ACTIVE: begin
                    if (inc_p) begin
                        addr_nx  = (addr_q == AW'(MAX_ADDR)) ? '0 : addr_q + AW'(1);
                        state_nx = SETTLE;
                        cnt_nx   = SCW'(SETTLE_CYC - 1);
                    end else if (state_q == SETTLE) begin
                        if (cnt_q == '0) state_nx = ACTIVE;
                        else             cnt_nx   = cnt_q - SCW'(1);
                    end
                end
                default: state_nx = HOLD;
            endcase
        end
    end

    // Outputs follow the next state so enable drops on the same edge the address moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HOLD;
            addr_q  <= '0;
            cnt_q   <= '0;
            inc_d   <= 1'b0;
            ena_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_nx;
            addr_q  <= addr_nx;
            cnt_q   <= cnt_nx;
            inc_d   <= inc_f;
            ena_q   <= (state_nx == ACTIVE) && ena_f;
            busy_q  <= (state_nx != ACTIVE);
        end
    end

    assign bus.sel_addr = addr_q;
    assign bus.sel_ena  = ena_q;
    assign bus.sel_busy = busy_q;
endmodule

// File: tb/tb_tt_ctrl_sel.sv
// Directed/randomised bench for tt_ctrl_sel: one default instance and one with
// MAX_ADDR=5 share the same pads; expected values come from the timing rules.
module tb_tt_ctrl_sel;
    localparam int MAX_A = 1023;
    localparam int MAX_B = 5;
    localparam int T_INC = 7;    // inc rising edge to address update
    localparam int T_ENA = 15;   // pad edge to ACTIVE (2 sync + 4 filt + 1 + 8 settle)

    logic clk = 1'b0;
    logic rst_n;
    logic pad_sel_rst_n, pad_sel_inc, pad_ena;
    int   errors = 0;
    int   checks = 0;
    int   exp_a  = 0;
    int   exp_b  = 0;

    always #5 clk = ~clk;

    tt_ctrl_sel_if #(.AW(10)) bus_a ();
    tt_ctrl_sel_if #(.AW(10)) bus_b ();

    assign bus_a.pad_sel_rst_n = pad_sel_rst_n;
    assign bus_a.pad_sel_inc   = pad_sel_inc;
    assign bus_a.pad_ena       = pad_ena;
    assign bus_b.pad_sel_rst_n = pad_sel_rst_n;
    assign bus_b.pad_sel_inc   = pad_sel_inc;
    assign bus_b.pad_ena       = pad_ena;

    tt_ctrl_sel #(.AW(10), .MAX_ADDR(MAX_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    tt_ctrl_sel #(.AW(10), .MAX_ADDR(MAX_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input int a, input int b,
                              input logic ena, input logic busy);
        check({tag, "_addr_a"}, 32'(bus_a.sel_addr), 32'(a));
        check({tag, "_addr_b"}, 32'(bus_b.sel_addr), 32'(b));
        check({tag, "_ena_a"},  32'(bus_a.sel_ena),  32'(ena));
        check({tag, "_ena_b"},  32'(bus_b.sel_ena),  32'(ena));
        check({tag, "_busy_a"}, 32'(bus_a.sel_busy), 32'(busy));
        check({tag, "_busy_b"}, 32'(bus_b.sel_busy), 32'(busy));
    endtask

    // One clean increment pulse of random width; optionally stop after stop_k edges.
    task automatic inc_pulse(input int stop_k);
        int h, gap, pa, pb;
        h   = $urandom_range(6, 10);
        gap = $urandom_range(0, 5);
        pa  = exp_a;
        pb  = exp_b;
        exp_a = (exp_a + 1) % (MAX_A + 1);
        exp_b = (exp_b + 1) % (MAX_B + 1);
        pad_sel_inc = 1'b1;
        for (int k = 1; k <= T_INC + 8; k++) begin
            tick();
            if (k == h) pad_sel_inc = 1'b0;
            check("b_range", 32'(bus_b.sel_addr <= 10'(MAX_B)), 32'd1);
            if (k == T_INC - 1)  check_outs("inc_pre",    pa,    pb,    1'b1, 1'b0);
            if (k == T_INC)      check_outs("inc_step",   exp_a, exp_b, 1'b0, 1'b1);
            if (k == T_INC + 7)  check_outs("inc_settle", exp_a, exp_b, 1'b0, 1'b1);
            if (k == T_INC + 8)  check_outs("inc_active", exp_a, exp_b, 1'b1, 1'b0);
            if (k == stop_k) return;
        end
        repeat (gap) begin
            tick();
            check("b_range", 32'(bus_b.sel_addr <= 10'(MAX_B)), 32'd1);
        end
    endtask

    initial begin
        int w;
        rst_n         = 1'b0;
        pad_sel_rst_n = 1'b1;
        pad_sel_inc   = 1'b0;
        pad_ena       = 1'b1;
        repeat (3) tick();
        check_outs("reset", 0, 0, 1'b0, 1'b1);

        // Release: ACTIVE exactly T_ENA edges after the pads are first sampled.
        rst_n = 1'b1;
        for (int k = 1; k <= T_ENA; k++) begin
            tick();
            if (k == T_ENA - 1) check_outs("rel_pre", 0, 0, 1'b0, 1'b1);
            if (k == T_ENA)     check_outs("rel_act", 0, 0, 1'b1, 1'b0);
        end

        repeat (3) inc_pulse(0);

        // Glitches shorter than the filter length never count.
        for (int g = 0; g < 3; g++) begin
            w = (g == 0) ? 3 : (g == 1) ? 1 : int'($urandom_range(1, 3));
            pad_sel_inc = 1'b1;
            repeat (w) tick();
            pad_sel_inc = 1'b0;
            for (int k = 0; k < 12; k++) begin
                tick();
                check("glitch_ena", 32'(bus_a.sel_ena), 32'd1);
            end
            check_outs("glitch", exp_a, exp_b, 1'b1, 1'b0);
        end

        // Four more: A reaches 7, B wraps 4,5,0,1.
        repeat (4) inc_pulse(0);
        check("a_is_7", 32'(bus_a.sel_addr), 32'd7);

        // Select reset with increments applied while it is held low.
        pad_sel_rst_n = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) check_outs("srst_pre", exp_a, exp_b, 1'b1, 1'b0);
            if (k == 7) check_outs("srst_hold", 0, 0, 1'b0, 1'b1);
        end
        exp_a = 0;
        exp_b = 0;
        for (int p = 0; p < 2; p++) begin
            pad_sel_inc = 1'b1;
            repeat (8) begin tick(); check("srst_addr", 32'(bus_a.sel_addr), 32'd0); end
            pad_sel_inc = 1'b0;
            repeat (8) begin tick(); check("srst_ena", 32'(bus_a.sel_ena), 32'd0); end
        end
        pad_sel_rst_n = 1'b1;
        for (int k = 1; k <= T_ENA; k++) begin
            tick();
            if (k == T_ENA - 1) check_outs("srel_pre", 0, 0, 1'b0, 1'b1);
            if (k == T_ENA)     check_outs("srel_act", 0, 0, 1'b1, 1'b0);
        end

        // Async reset mid-SETTLE with address 4 and settle counter at 3.
        repeat (3) inc_pulse(0);
        inc_pulse(T_INC + 4);
        check_outs("mid_settle", 4, 4, 1'b0, 1'b1);
        rst_n = 1'b0;
        #2;
        check_outs("async_rst", 0, 0, 1'b0, 1'b1);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
